// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle control FSM.
//   state_t   : phase encodings (IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5)
//   OP_*      : opcode field values the controller sequences
//   ALUOP_*   : ALU operation selects
//   strobe_t  : bundle of datapath enables produced per phase
// Optional: MULTICYCLE_ILLEGAL_TRAP_EN adds the TRAP encoding.
package multicycle_pkg;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;
`endif

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
  } strobe_t;

  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LD) || (op == OP_SD) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle.
//   master : the controller (consumes opcode/zero/mem_ready, drives enables)
//   slave  : the datapath side
// Optional: MULTICYCLE_ILLEGAL_TRAP_EN adds the illegal flag.
interface multicycle_controller_if #(
  parameter int RET_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             alu_src;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             retired;
  logic [RET_W-1:0] retired_count;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  modport master (
    input  opcode, zero, mem_ready,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    output illegal,
`endif
    output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
    output mem_to_reg, alu_src, alu_op, state, retired, retired_count
  );

  modport slave (
    output opcode, zero, mem_ready,
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    input  illegal,
`endif
    input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
    input  mem_to_reg, alu_src, alu_op, state, retired, retired_count
  );
endinterface

// File: rtl/multicycle_out_decode.sv
// Combinational map from (phase, latched opcode) to datapath enables.
//   state : current phase
//   op_q  : opcode captured at the end of ID
//   zero  : ALU zero flag, only consulted for the branch in EX
//   strb  : enables; all zero in unused or trap phases
module multicycle_out_decode
  import multicycle_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] op_q,
  input  logic       zero,
  output strobe_t    strb
);

  always_comb begin
    strb = '0;
    case (state)
      S_IF: begin
        strb.ir_write = 1'b1;
        strb.pc_write = 1'b1;
      end
      S_EX: begin
        case (op_q)
          OP_RTYPE: strb.alu_op = ALUOP_FUNCT;
          OP_LD, OP_SD: begin
            strb.alu_src = 1'b1;
            strb.alu_op  = ALUOP_ADD;
          end
          OP_BEQ: begin
            strb.alu_op   = ALUOP_SUB;
            strb.pc_src   = 1'b1;
            strb.pc_write = zero;
          end
          default: strb = '0;
        endcase
      end
      S_MEM: begin
        // Address stays on the ALU while memory is busy.
        strb.alu_src   = 1'b1;
        strb.alu_op    = ALUOP_ADD;
        strb.mem_read  = (op_q == OP_LD);
        strb.mem_write = (op_q == OP_SD);
      end
      S_WB: begin
        strb.reg_write  = 1'b1;
        strb.mem_to_reg = (op_q == OP_LD);
      end
      default: strb = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences one instruction at a time through
// IF/ID/EX/MEM/WB and counts retired instructions.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces every output to 0 while high
//   bus   : master side of multicycle_controller_if
// Parameter RET_W: retired_count width (wraps modulo 2^RET_W).
// Optional: MULTICYCLE_ILLEGAL_TRAP_EN sends unknown opcodes to a sticky
// TRAP state with bus.illegal=1 instead of treating them as NOPs.
//
// state | meaning
// IF    | fetch: load IR, PC <= PC+4
// ID    | decode: capture opcode into op_q, choose path
// EX    | execute: ALU op per op_q; beq resolves and retires here
// MEM   | data access, held until mem_ready; sd retires here
// WB    | register-file write; R/ld retire here
// TRAP  | unknown opcode, held until reset (trap build only)
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int RET_W = 32
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  state_t           state_q;
  logic [6:0]       op_q;
  logic [RET_W-1:0] cnt_q;
  logic             retired_c;
  strobe_t          strb;

  assign retired_c = !reset &&
                     (((state_q == S_EX) && (op_q == OP_BEQ)) ||
                      ((state_q == S_MEM) && (op_q == OP_SD) && bus.mem_ready) ||
                      (state_q == S_WB));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (retired_c) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          op_q <= bus.opcode;
          if (is_known_op(bus.opcode)) state_q <= S_EX;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          else state_q <= S_TRAP;
`else
          else state_q <= S_IF;
`endif
        end
        S_EX: begin
          case (op_q)
            OP_RTYPE:     state_q <= S_WB;
            OP_LD, OP_SD: state_q <= S_MEM;
            default:      state_q <= S_IF;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) state_q <= (op_q == OP_LD) ? S_WB : S_IF;
        end
        S_WB: state_q <= S_IF;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        S_TRAP: state_q <= S_TRAP;
`endif
        default: state_q <= S_IF;
      endcase
    end
  end

  multicycle_out_decode u_decode (
    .state (state_q),
    .op_q  (op_q),
    .zero  (bus.zero),
    .strb  (strb)
  );

  // Outputs are gated by reset so a reset mid-MEM drops strobes immediately.
  assign bus.pc_write      = !reset && strb.pc_write;
  assign bus.pc_src        = !reset && strb.pc_src;
  assign bus.ir_write      = !reset && strb.ir_write;
  assign bus.reg_write     = !reset && strb.reg_write;
  assign bus.mem_read      = !reset && strb.mem_read;
  assign bus.mem_write     = !reset && strb.mem_write;
  assign bus.mem_to_reg    = !reset && strb.mem_to_reg;
  assign bus.alu_src       = !reset && strb.alu_src;
  assign bus.alu_op        = reset ? 2'b00 : strb.alu_op;
  assign bus.state         = reset ? 3'd0 : state_q;
  assign bus.retired       = retired_c;
  assign bus.retired_count = reset ? '0 : cnt_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign bus.illegal       = !reset && (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle traces are
// generated from the phase rules into a vector table, then applied one
// vector per clock and compared before the next rising edge.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  localparam int RET_W = 3;

  logic clk;
  logic reset;

  multicycle_controller_if #(.RET_W(RET_W)) bus ();

  multicycle_controller #(.RET_W(RET_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic             retired;
    logic [RET_W-1:0] count;
    logic             illegal;
  } out_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic [6:0] opc;
    logic       zero;
    logic       mrdy;
    out_t       exp;
  } vec_t;

  vec_t  vecs[$];
  int    model_cnt;
  int    n_vec;
  int    n_bad;
  string cur_tag;

  function automatic out_t idle();
    out_t e;
    e = '0;
    return e;
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst, input logic [6:0] opc, input logic z,
                      input logic mrdy, input out_t e);
    vec_t v;
    v.tag  = cur_tag;
    v.rst  = rst;
    v.opc  = opc;
    v.zero = z;
    v.mrdy = mrdy;
    v.exp  = e;
    if (rst) begin
      v.exp     = '0;
      model_cnt = 0;
    end else begin
      v.exp.count = RET_W'(model_cnt);
      if (e.retired) model_cnt = (model_cnt + 1) % (1 << RET_W);
    end
    vecs.push_back(v);
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, r7(), r1(), r1(), idle());
  endtask

  // Expected trace of one instruction; opcode is only meaningful in ID and
  // is randomised elsewhere so a missing op_q latch shows up.
  task automatic add_instr(input logic [6:0] opc, input logic z, input int waits);
    out_t e;
    logic last;
    e = idle(); e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b0, r7(), r1(), r1(), e);
    e = idle(); e.state = 3'd1;
    push(1'b0, opc, r1(), r1(), e);
    if (opc == OP_BEQ) begin
      e = idle(); e.state = 3'd2; e.alu_op = 2'b01; e.pc_src = 1'b1;
      e.pc_write = z; e.retired = 1'b1;
      push(1'b0, r7(), z, r1(), e);
    end else if (opc == OP_RTYPE) begin
      e = idle(); e.state = 3'd2; e.alu_op = 2'b10;
      push(1'b0, r7(), r1(), r1(), e);
      e = idle(); e.state = 3'd4; e.reg_write = 1'b1; e.retired = 1'b1;
      push(1'b0, r7(), r1(), r1(), e);
    end else if (opc == OP_LD || opc == OP_SD) begin
      e = idle(); e.state = 3'd2; e.alu_src = 1'b1;
      push(1'b0, r7(), r1(), r1(), e);
      for (int w = 0; w <= waits; w++) begin
        last = (w == waits);
        e = idle(); e.state = 3'd3; e.alu_src = 1'b1;
        e.mem_read  = (opc == OP_LD);
        e.mem_write = (opc == OP_SD);
        e.retired   = last && (opc == OP_SD);
        push(1'b0, r7(), r1(), last, e);
      end
      if (opc == OP_LD) begin
        e = idle(); e.state = 3'd4; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        e.retired = 1'b1;
        push(1'b0, r7(), r1(), r1(), e);
      end
    end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      for (int t = 0; t < 10; t++) begin
        e = idle(); e.state = 3'd5; e.illegal = 1'b1;
        push(1'b0, r7(), r1(), r1(), e);
      end
      push_reset(1);
`endif
    end
  endtask

  out_t act;

  initial begin
    logic [6:0] opc;
    out_t e;
    int k;
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    n_vec     = 0;
    n_bad     = 0;
    model_cnt = 0;

    cur_tag = "reset";    push_reset(2);
    cur_tag = "rtype";    add_instr(OP_RTYPE, 1'b0, 0);
    cur_tag = "ld_wait2"; add_instr(OP_LD, 1'b0, 2);
    cur_tag = "beq_z1";   add_instr(OP_BEQ, 1'b1, 0);
    cur_tag = "beq_z0";   add_instr(OP_BEQ, 1'b0, 0);
    cur_tag = "sd_ready"; add_instr(OP_SD, 1'b0, 0);

    // sd with reset in its second MEM cycle
    cur_tag = "sd_mid_reset";
    e = idle(); e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b0, r7(), r1(), r1(), e);
    e = idle(); e.state = 3'd1;
    push(1'b0, OP_SD, r1(), r1(), e);
    e = idle(); e.state = 3'd2; e.alu_src = 1'b1;
    push(1'b0, r7(), r1(), r1(), e);
    e = idle(); e.state = 3'd3; e.alu_src = 1'b1; e.mem_write = 1'b1;
    push(1'b0, r7(), r1(), 1'b0, e);
    push(1'b1, r7(), r1(), 1'b0, idle());
    cur_tag = "after_reset"; add_instr(OP_RTYPE, 1'b0, 0);

    cur_tag = "illegal"; add_instr(7'b0000000, 1'b0, 0);

    cur_tag = "wrap";
    push_reset(1);
    for (int i = 0; i < 9; i++) add_instr(OP_RTYPE, 1'b0, 0);

    cur_tag = "random";
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0:       opc = OP_RTYPE;
        1:       opc = OP_LD;
        2:       opc = OP_SD;
        3:       opc = OP_BEQ;
        default: opc = r7();
      endcase
      add_instr(opc, r1(), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) push_reset(1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      bus.opcode    = vecs[i].opc;
      bus.zero      = vecs[i].zero;
      bus.mem_ready = vecs[i].mrdy;
      #2;
      act.pc_write   = bus.pc_write;
      act.pc_src     = bus.pc_src;
      act.ir_write   = bus.ir_write;
      act.reg_write  = bus.reg_write;
      act.mem_read   = bus.mem_read;
      act.mem_write  = bus.mem_write;
      act.mem_to_reg = bus.mem_to_reg;
      act.alu_src    = bus.alu_src;
      act.alu_op     = bus.alu_op;
      act.state      = bus.state;
      act.retired    = bus.retired;
      act.count      = bus.retired_count;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      act.illegal    = bus.illegal;
`else
      act.illegal    = 1'b0;
`endif
      n_vec++;
      if (act !== vecs[i].exp) begin
        n_bad++;
        $display("FAIL %s vec %0d: got %h required %h", vecs[i].tag, i, act, vecs[i].exp);
      end
      if (vecs[i].rst && (act !== out_t'('0))) begin
        n_bad++;
        $display("FAIL %s vec %0d: reset-state outputs not all zero, got %h",
                 vecs[i].tag, i, act);
      end
      if (!vecs[i].rst && (vecs[i].exp.state == 3'd3) && !vecs[i].mrdy &&
          ((act.mem_read  !== vecs[i].exp.mem_read)  ||
           (act.mem_write !== vecs[i].exp.mem_write) ||
           (act.retired   !== 1'b0))) begin
        n_bad++;
        $display("FAIL %s vec %0d: MEM wait not held (rd=%b wr=%b ret=%b)",
                 vecs[i].tag, i, act.mem_read, act.mem_write, act.retired);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    if (n_bad != 0 || n_vec < 12)
      $display("FAIL: %0d miscompares over %0d vectors", n_bad, n_vec);
    else
      $display("PASS");
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM that sequences the decode/register-file/immediate datapath one instruction at a time through the phases IF, ID, EX, MEM and WB.
- Replaces the single-cycle combinational control decode with per-phase strobes.
- Gates register-file writes so they happen only in WB.
- Sits between the instruction register opcode field and the datapath enables: PC, IR, register file, ALU and data memory.

Parameters:
RET_W, 32, width of the retired-instruction counter; wraps modulo 2^RET_W.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0], valid from the cycle after ir_write
zero  input  1  ALU zero flag, valid in EX
mem_ready  input  1  data-memory completion, sampled in MEM
pc_write  output  1  PC load enable
pc_src  output  1  0 = PC+4, 1 = branch target
ir_write  output  1  IR load enable
reg_write  output  1  register-file write enable
mem_read  output  1  data-memory read strobe
mem_write  output  1  data-memory write strobe
mem_to_reg  output  1  write-back select: 1 = memory, 0 = ALU
alu_src  output  1  0 = rs2, 1 = immediate
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
state  output  3  current state, for debug
retired  output  1  one-cycle pulse when an instruction completes
retired_count  output  RET_W  number of completed instructions

Behaviour:
- State register updates on the clk edge. On reset: state=IF, op_q=0, retired_count=0.
- All strobe outputs are Moore, decoded combinationally from (state, op_q).
- Every output is forced to 0 in any cycle where reset=1. This includes a reset in the middle of MEM: mem_read/mem_write drop in that same cycle.
- op_q is the opcode latched at the end of ID.
- IF: ir_write=1, pc_write=1, pc_src=0. Next state is ID unconditionally.
- ID: no strobes; latch op_q<=opcode. Next state by opcode:
  - 0110011 (R), 0000011 (ld), 0100011 (sd), 1100011 (beq) -> EX.
  - Any other opcode -> IF. Acts as a NOP: not retired, no writes.
- EX:
  - R: alu_src=0, alu_op=10.
  - ld/sd: alu_src=1, alu_op=00.
  - beq: alu_src=0, alu_op=01, pc_src=1, pc_write=zero.
  - Transitions: R -> WB; ld/sd -> MEM; beq -> IF with retired=1.
- MEM: alu_src=1, alu_op=00 are held.
  - ld: mem_read=1. sd: mem_write=1.
  - Strobes stay high until mem_ready=1, which may arrive in the first MEM cycle.
  - On mem_ready, ld -> WB; sd -> IF with retired=1.
  - mem_ready is ignored in every state other than MEM.
- WB: reg_write=1; mem_to_reg=1 for ld, 0 for R. Next state IF, retired=1.
- Cycle counts with mem_ready already high:
  - beq: 3 cycles.
  - R: 4 cycles.
  - sd: 4 cycles, plus 1 per MEM wait cycle.
  - ld: 5 cycles, plus 1 per MEM wait cycle.
- retired_count increments on each cycle where retired=1 and wraps from all-ones to 0.
- Strobe exclusivity: at most one of reg_write, mem_read, mem_write is high in any cycle.
- Unused state encodings recover to IF on the next edge with all strobes 0.

Optional Feature:
Macro MULTICYCLE_ILLEGAL_TRAP_EN.
- When defined:
  - Adds output port illegal (1 bit) and state TRAP.
  - An unknown opcode in ID -> TRAP.
  - TRAP is sticky until reset: all strobes 0, illegal=1, no retire.
- When undefined:
  - No port and no TRAP state.
  - Unknown opcodes take the NOP path back to IF as described above.

Decomposition:
- Package multicycle_pkg:
  - State encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
  - Opcode constants: OP_RTYPE, OP_LD, OP_SD, OP_BEQ.
  - ALU-op constants: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT.
- One natural sub-module, multicycle_out_decode: purely combinational map from (state, op_q) to the strobe outputs. The parent holds the state register, op_q and the counter.

Test Plan:
- R-type: reset 2 cycles, opcode=0110011 -> state sequence IF,ID,EX,WB,IF; reg_write=1 only in WB with mem_to_reg=0; retired pulses once; retired_count=1.
- ld with latency: opcode=0000011, mem_ready low for 2 MEM cycles -> mem_read high for 3 cycles, then WB with mem_to_reg=1; 7 cycles total.
- beq both ways: opcode=1100011, zero=1 -> pc_write=1, pc_src=1 in EX, 3 cycles; repeat with zero=0 -> pc_write=0 in EX.
- sd plus reset mid-MEM: opcode=0100011, mem_ready=0; assert reset in the 2nd MEM cycle -> mem_write=0 in that cycle, state=IF after the edge, retired_count=0.
- Illegal opcode 0000000:
  - Trap macro undefined -> IF,ID,IF with no strobes and no retire.
  - Trap macro defined -> TRAP, illegal=1, held 10 cycles until reset.
- Counter wrap: RET_W=3, run 8 back-to-back R-type instructions -> retired_count returns to 0.
